seg7_ctrl: RTL and testbench
============================

Name: seg7_ctrl

Overview:
- Upstream feeder for the 7-segment display device.
- Holds the display register file (`data`, `point`, `LES`), written over a simple write port.
- Generates the digit-scan phase `clkScan` and the blink phase `clkBlink`.
- Includes a sequential binary-to-BCD converter (double-dabble), so game logic (timer, mine counter) can post a binary value and have its 4 decimal digits land in `data[15:0]`.

Parameters:
- SCAN_DIV, default 17: width of the free-running scan counter; `clkScan` = `scan_cnt[SCAN_DIV-1:SCAN_DIV-2]`; legal range >= 2.
- BLINK_DIV, default 25: width of the blink counter; `clkBlink` = `blink_cnt[BLINK_DIV-1]`; legal range >= 1.

Ports:
- clk  in  1  single system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one-cycle effective.
- wr_addr  in  2  0=data, 1=point, 2=LES, 3=reserved (write ignored).
- wr_data  in  32  write value; `point`/`LES` take bits [7:0].
- bin_valid  in  1  conversion request.
- bin_value  in  14  unsigned binary value to convert.
- bin_ready  out  1  converter idle and able to accept.
- data  out  32  hex nibbles to display (registered).
- point  out  8  decimal-point enables (registered).
- LES  out  8  per-digit blink enables (registered).
- clkScan  out  2  digit-scan phase.
- clkBlink  out  1  blink phase.

Behaviour:
- Reset (`rst`=1 at an edge):
  - `data`, `point`, `LES` and both counters are cleared to 0, so `clkScan`=0 and `clkBlink`=0.
  - The FSM goes to IDLE.
  - `bin_ready`=0 while `rst` is high; it is 1 in the first cycle after `rst` falls.
- Counters:
  - `scan_cnt` and `blink_cnt` increment by 1 every clock and wrap naturally (all-ones -> 0).
  - Neither is affected by writes or conversions.
- Register writes:
  - When `wr_en`=1, the addressed register takes `wr_data` at that edge and is visible the next cycle.
  - Address 3 has no effect.
- FSM has three states: IDLE, CONV, DONE.
  - IDLE: `bin_ready`=1. On `bin_valid` && `bin_ready` (edge E0):
    - capture min(`bin_value`, 9999) into a 14-bit shift register;
    - clear a 16-bit BCD accumulator;
    - set `iter`=0 and go to CONV.
  - CONV: `bin_ready`=0. Each edge performs one double-dabble step:
    - every BCD nibble >= 5 gets +3;
    - then {bcd, bin} shifts left by 1;
    - `iter`++.
    - After 14 steps (edges E1..E14) go to DONE.
  - DONE: at edge E15, `data[15:0]` <= bcd, `data[31:16]` is unchanged, and the FSM returns to IDLE. `bin_ready`=1 from the cycle after E15.
  - Total latency from accept edge to `data` update: 15 clocks.
  - Back-to-back requests: the earliest next accept edge is E16.
- `bin_valid` during CONV/DONE is ignored; no queueing.
- Simultaneous events:
  - If `wr_en` to address 0 coincides with edge E15, the bus write wins for all 32 bits and the conversion result is discarded. The FSM still returns to IDLE.
  - Writes to `point`/`LES` at E15 are unaffected by the conversion.
- Reset mid-conversion aborts it: no `data` update occurs and the FSM is in IDLE after reset.

Optional Feature:
- Macro: SEG7_OVF_POINT_EN.
- Defined:
  - A request with `bin_value` > 9999 records an overflow flag at accept.
  - At E15 the conversion writes 9999 and sets `point[3:0]`=4'hF.
  - A non-overflow conversion completing at E15 clears `point[3:0]`=4'h0.
  - `point[7:4]` is untouched in both cases.
  - A simultaneous bus write to `point` at E15 wins.
- Undefined:
  - Overflow inputs saturate silently to 9999.
  - The converter never modifies `point`.

Test Plan:
- Reset then idle (SCAN_DIV=4, BLINK_DIV=3):
  - all outputs are 0 during `rst`;
  - `clkScan` sequence is 0 for 4 clocks, then 1, 2, 3, wrapping every 16 clocks;
  - `clkBlink` toggles every 4 clocks;
  - `bin_ready`=1 after release.
- Write `data`=0xDEADBEEF, `point`=0x81, `LES`=0x0F, then write to address 3 -> outputs show the written values next cycle; the address-3 write changes nothing.
- Preload `data`=0xABCD0000, request `bin_value`=1234 -> `bin_ready` low for 15 cycles; `data`=0xABCD1234 exactly 15 clocks after accept.
- Request 16383 -> `data[15:0]`=0x9999. With SEG7_OVF_POINT_EN, `point[3:0]`=F; a following request of 7 gives 0x0007 and `point[3:0]`=0.
- Request 500; at E15 write `data`=0x11111111 -> `data`=0x11111111 next cycle; `bin_ready` returns to 1.
- Request 42; assert `rst` at E8; request 9 after release -> no 0x0042 update ever appears; second result 0x0009 lands 15 clocks after its accept.

Source files
------------

// File: rtl/seg7_ctrl.sv
// Display register file, scan/blink phase counters and a 14-step double-dabble BCD converter.
// Conversion latency 15 clocks from accept; bin_ready drops while busy. Option: SEG7_OVF_POINT_EN flags overflow on point[3:0].
module seg7_ctrl #(
    parameter int SCAN_DIV  = 17,
    parameter int BLINK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        bin_valid,
    input  logic [13:0] bin_value,
    output logic        bin_ready,
    output logic [31:0] data,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic [1:0]  clkScan,
    output logic        clkBlink
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [13:0] BIN_MAX = 14'd9999;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SCAN_DIV-1:0]    r_scan_cnt;
    logic [BLINK_DIV-1:0]   r_blink_cnt;
    logic [31:0]            r_data;
    logic [7:0]             r_point;
    logic [7:0]             r_les;
    logic [13:0]            r_bin;
    logic [15:0]            r_bcd;
    logic [3:0]             r_iter;
    logic [15:0]            w_bcd_adj;
    logic [13:0]            w_bin_sat;
    logic                   w_accept;
    logic                   w_wr_data;
    logic                   w_wr_point;
    logic                   w_wr_les;
`ifdef SEG7_OVF_POINT_EN
    logic                   r_ovf;
`endif

    assign w_wr_data  = wr_en && (wr_addr == 2'd0);
    assign w_wr_point = wr_en && (wr_addr == 2'd1);
    assign w_wr_les   = wr_en && (wr_addr == 2'd2);
    assign w_bin_sat  = (bin_value > BIN_MAX) ? BIN_MAX : bin_value;
    assign w_accept   = bin_valid && bin_ready;

    // Ready is gated by rst so no request can be taken during reset.
    assign bin_ready = (r_state == IDLE) && !rst;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = CONV;
            CONV: if (r_iter == 4'd13) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_scan_cnt  <= r_scan_cnt + {{(SCAN_DIV-1){1'b0}}, 1'b1};
            r_blink_cnt <= r_blink_cnt + {{(BLINK_DIV-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_bin  <= w_bin_sat;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == CONV) begin
            r_bcd  <= {w_bcd_adj[14:0], r_bin[13]};
            r_bin  <= {r_bin[12:0], 1'b0};
            r_iter <= r_iter + 4'd1;
        end
    end

`ifdef SEG7_OVF_POINT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_ovf <= (bin_value > BIN_MAX);
        end
    end
`endif

    // A bus write always beats the converter result landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_wr_data) begin
            r_data <= wr_data;
        end else if (r_state == DONE) begin
            r_data[15:0] <= r_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_point <= '0;
        end else if (w_wr_point) begin
            r_point <= wr_data[7:0];
`ifdef SEG7_OVF_POINT_EN
        end else if (r_state == DONE) begin
            r_point[3:0] <= r_ovf ? 4'hF : 4'h0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_les <= '0;
        end else if (w_wr_les) begin
            r_les <= wr_data[7:0];
        end
    end

    assign data     = r_data;
    assign point    = r_point;
    assign LES      = r_les;
    assign clkScan  = r_scan_cnt[SCAN_DIV-1:SCAN_DIV-2];
    assign clkBlink = r_blink_cnt[BLINK_DIV-1];

endmodule

// File: tb/tb_seg7_ctrl.sv
// Directed self-checking bench for seg7_ctrl with small scan/blink counters.
module tb_seg7_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic        bin_valid = 1'b0;
    logic [13:0] bin_value = 14'd0;
    logic        bin_ready;
    logic [31:0] data;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic [1:0]  clkScan;
    logic        clkBlink;

    int checks = 0;
    int errors = 0;

    seg7_ctrl #(.SCAN_DIV(4), .BLINK_DIV(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bin_valid (bin_valid),
        .bin_value (bin_value),
        .bin_ready (bin_ready),
        .data      (data),
        .point     (point),
        .LES       (LES),
        .clkScan   (clkScan),
        .clkBlink  (clkBlink)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_accept(input logic [13:0] v);
        bin_valid = 1'b1;
        bin_value = v;
        tick();
        bin_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_scan;
        logic       exp_blink;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({data, point, LES, clkScan, clkBlink, bin_ready} !== 52'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h point=%h LES=%h scan=%0d blink=%0d rdy=%0d, want all 0",
                     data, point, LES, clkScan, clkBlink, bin_ready);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            exp_scan  = 2'((k >> 2) & 3);
            exp_blink = 1'((k >> 2) & 1);
            checks++;
            if (clkScan !== exp_scan || clkBlink !== exp_blink) begin
                errors++;
                $display("FAIL counters k=%0d: got scan=%0d blink=%0d, want scan=%0d blink=%0d",
                         k, clkScan, clkBlink, exp_scan, exp_blink);
            end
            if (k == 0) begin
                checks++;
                if (bin_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_reset: got %0d want 1", bin_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_writes();
        bus_write(2'd0, 32'hDEADBEEF);
        checks++;
        if (data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_data: got %h want deadbeef", data);
        end
        bus_write(2'd1, 32'hFFFF_FF81);
        checks++;
        if (point !== 8'h81) begin
            errors++;
            $display("FAIL write_point: got %h want 81", point);
        end
        bus_write(2'd2, 32'h0000_000F);
        checks++;
        if (LES !== 8'h0F) begin
            errors++;
            $display("FAIL write_les: got %h want 0f", LES);
        end
        bus_write(2'd3, 32'h12345678);
        checks++;
        if (data !== 32'hDEADBEEF || point !== 8'h81 || LES !== 8'h0F) begin
            errors++;
            $display("FAIL write_addr3: got data=%h point=%h LES=%h want deadbeef/81/0f", data, point, LES);
        end
    endtask

    task automatic test_convert_1234();
        bus_write(2'd0, 32'hABCD0000);
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_1234: got %0d want 1", bin_ready);
        end
        do_accept(14'd1234);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (bin_ready !== 1'b0 || data !== 32'hABCD0000) begin
                errors++;
                $display("FAIL busy_1234 cyc=%0d: got rdy=%0d data=%h want rdy=0 data=abcd0000", i, bin_ready, data);
            end
            tick();
        end
        checks++;
        if (data !== 32'hABCD1234 || bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_1234: got data=%h rdy=%0d want abcd1234 rdy=1", data, bin_ready);
        end
    endtask

    task automatic test_saturate();
        do_accept(14'd16383);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (data !== 32'hABCD9999) begin
            errors++;
            $display("FAIL result_16383: got %h want abcd9999", data);
        end
        checks++;
`ifdef SEG7_OVF_POINT_EN
        if (point !== 8'h8F) begin
            errors++;
            $display("FAIL ovf_point_set: got %h want 8f", point);
        end
`else
        if (point !== 8'h81) begin
            errors++;
            $display("FAIL point_untouched_ovf: got %h want 81", point);
        end
`endif
        do_accept(14'd7);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (data !== 32'hABCD0007) begin
            errors++;
            $display("FAIL result_7: got %h want abcd0007", data);
        end
        checks++;
`ifdef SEG7_OVF_POINT_EN
        if (point !== 8'h80) begin
            errors++;
            $display("FAIL ovf_point_clear: got %h want 80", point);
        end
`else
        if (point !== 8'h81) begin
            errors++;
            $display("FAIL point_untouched_7: got %h want 81", point);
        end
`endif
    endtask

    task automatic test_write_collision();
        do_accept(14'd500);
        for (int i = 0; i < 14; i++) tick();
        bus_write(2'd0, 32'h11111111);
        checks++;
        if (data !== 32'h11111111 || bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision: got data=%h rdy=%0d want 11111111 rdy=1", data, bin_ready);
        end
        tick();
        checks++;
        if (data !== 32'h11111111) begin
            errors++;
            $display("FAIL collision_hold: got %h want 11111111", data);
        end
    endtask

    task automatic test_reset_abort();
        do_accept(14'd42);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (data !== 32'd0 || bin_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got data=%h rdy=%0d want 0 rdy=0", data, bin_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %0d want 1", bin_ready);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (data !== 32'd0) begin
                errors++;
                $display("FAIL abort_no_update cyc=%0d: got %h want 0", i, data);
            end
        end
        do_accept(14'd9);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (data !== 32'd0) begin
                errors++;
                $display("FAIL busy_9 cyc=%0d: got %h want 0", i, data);
            end
            tick();
        end
        checks++;
        if (data !== 32'h00000009 || bin_ready !== 1'b1) begin
            errors++;
            $display("FAIL result_9: got data=%h rdy=%0d want 00000009 rdy=1", data, bin_ready);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_convert_1234();
        test_saturate();
        test_write_collision();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
